// File: rtl/ahb_uart_debug_manager.sv
// rtl/ahb_uart_debug_manager.sv - UART byte-frame to AHB-Lite single-word manager
// Host frames: W a3..a0 d3..d0 / R a3..a0; replies ACK(+data) or NAK.
module ahb_uart_debug_manager #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
   parameter logic [7:0]  CMD_WRITE      = 8'h57,
   parameter logic [7:0]  CMD_READ       = 8'h52
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [31:0] haddr,
   output logic [1:0]  htrans,
   output logic        hwrite,
   output logic [2:0]  hsize,
   output logic [31:0] hwdata,
   input  logic [31:0] hrdata,
   input  logic        hready,
   input  logic        hresp,
   output logic        busy,
   output logic        drop
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_BUS_A, S_BUS_D, S_RESP, S_TX_REQ, S_TX_WAIT
   } state_t;

   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   state_t      state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        nak_q, nak_d;
   logic        err_q, err_d;
   logic [31:0] timer_q, timer_d;
   logic [39:0] tx_sh_q, tx_sh_d;
   logic [2:0]  tx_left_q, tx_left_d;
   logic        drop_q, drop_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         is_wr_q   <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         nak_q     <= 1'b0;
         err_q     <= 1'b0;
         timer_q   <= '0;
         tx_sh_q   <= '0;
         tx_left_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         nak_q     <= nak_d;
         err_q     <= err_d;
         timer_q   <= timer_d;
         tx_sh_q   <= tx_sh_d;
         tx_left_q <= tx_left_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      nak_d     = nak_q;
      err_d     = err_q;
      timer_d   = timer_q;
      tx_sh_d   = tx_sh_q;
      tx_left_d = tx_left_q;
      drop_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_done) begin
               cnt_d   = '0;
               timer_d = '0;
               if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                  is_wr_d = (rx_data == CMD_WRITE);
                  nak_d   = 1'b0;
                  state_d = S_ADDR;
               end else begin
                  nak_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_ADDR, S_WDATA: begin
            if (rx_done) begin
               timer_d = '0;
               cnt_d   = cnt_q + 4'd1;
               if (state_q == S_ADDR) addr_d  = {addr_q[23:0], rx_data};
               else                   wdata_d = {wdata_q[23:0], rx_data};
               if (cnt_q == 4'd3) begin
                  cnt_d = '0;
                  if (state_q == S_ADDR && is_wr_q) begin
                     state_d = S_WDATA;
                  end else if (addr_d[1:0] != 2'b00) begin
                     // Misaligned word: refuse without touching the bus.
                     nak_d   = 1'b1;
                     state_d = S_RESP;
                  end else begin
                     state_d = S_BUS_A;
                  end
               end
            end else if (timer_q >= TIMEOUT_CYCLES - 32'd1) begin
               timer_d = '0;
               drop_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_BUS_A: begin
            if (hready) begin
               err_d   = 1'b0;
               state_d = S_BUS_D;
            end
         end
         S_BUS_D: begin
            if (hresp) err_d = 1'b1;
            if (hready) begin
               rdata_d = hrdata;
               nak_d   = err_q | hresp;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (nak_q) begin
               tx_sh_d   = {NAK, 32'h0};
               tx_left_d = 3'd1;
            end else if (is_wr_q) begin
               tx_sh_d   = {ACK, 32'h0};
               tx_left_d = 3'd1;
            end else begin
               tx_sh_d   = {ACK, rdata_q};
               tx_left_d = 3'd5;
            end
            state_d = S_TX_REQ;
         end
         S_TX_REQ: begin
            if (tx_busy) state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (!tx_busy) begin
               if (tx_left_q <= 3'd1) begin
                  tx_left_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  tx_left_d = tx_left_q - 3'd1;
                  tx_sh_d   = {tx_sh_q[31:0], 8'h00};
                  state_d   = S_TX_REQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_done && state_q != S_IDLE && state_q != S_ADDR && state_q != S_WDATA)
         drop_d = 1'b1;
   end

   assign htrans   = (state_q == S_BUS_A) ? 2'b10 : 2'b00;
   assign hwrite   = (state_q == S_BUS_A) && is_wr_q;
   assign hsize    = 3'b010;
   assign haddr    = addr_q;
   assign hwdata   = wdata_q;
   assign tx_start = (state_q == S_TX_REQ);
   assign tx_data  = tx_sh_q[39:32];
   assign busy     = (state_q != S_IDLE);
   assign drop     = drop_q;

endmodule
